// File: rtl/prog_mem_responder_pkg.sv
// Shared state encoding and default parameters for the
// program-memory responder and its round-robin arbiter.
package prog_mem_pkg;

    localparam int DEF_NUM_CONSUMERS = 4;
    localparam int DEF_ADDR_BITS     = 8;
    localparam int DEF_DATA_BITS     = 16;
    localparam int DEF_DEPTH         = 256;
    localparam int DEF_READ_LATENCY  = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

endpackage

// File: rtl/prog_mem_responder_if.sv
// Fetcher read channels plus the host program-load port.
// master = fetchers/host side, slave = responder side.
interface prog_mem_responder_if
    import prog_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS
) ();

    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic                               load_valid;
    logic [ADDR_BITS-1:0]               load_address;
    logic [DATA_BITS-1:0]               load_data;

    modport master (
        output consumer_read_valid,
        output consumer_read_address,
        input  consumer_read_ready,
        input  consumer_read_data,
        output load_valid,
        output load_address,
        output load_data
    );

    modport slave (
        input  consumer_read_valid,
        input  consumer_read_address,
        output consumer_read_ready,
        output consumer_read_data,
        input  load_valid,
        input  load_address,
        input  load_data
    );

endinterface

// File: rtl/prog_mem_responder_arbiter.sv
// Round-robin arbiter: first unmasked request at or after
// pointer wins; returns one-hot grant and its index.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [N-1:0]        request,
    input  logic [N-1:0]        mask,
    input  logic [PTR_BITS-1:0] pointer,
    output logic [N-1:0]        grant,
    output logic [PTR_BITS-1:0] grant_index,
    output logic                grant_valid
);

    localparam logic [PTR_BITS:0] N_LIM = (PTR_BITS + 1)'(N);

    logic [N-1:0]      eligible;
    logic [N-1:0]      rotated;
    logic [PTR_BITS:0] sum;

    assign eligible = request & ~mask;
    assign rotated  = N'({eligible, eligible} >> pointer);

    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        sum         = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && rotated[i]) begin
                grant_valid = 1'b1;
                sum = {1'b0, pointer} + (PTR_BITS + 1)'(i);
                if (sum >= N_LIM) sum = sum - N_LIM;
                grant_index = sum[PTR_BITS-1:0];
            end
        end
        if (grant_valid) grant[grant_index] = 1'b1;
    end

endmodule

// File: rtl/prog_mem_responder.sv
// Shared program memory serving N fetchers one read at a time.
// Define PROG_MEM_OOR_CHECK_EN to zero-fill and flag reads >= DEPTH.
module prog_mem_responder
    import prog_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int READ_LATENCY  = DEF_READ_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_mem_responder_if.slave  bus,
    output logic                 busy,
    output logic                 oor_error
);

    localparam int PTR_BITS = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    localparam int IDX_BITS = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

    localparam logic [CNT_BITS-1:0]  CNT_INIT  = CNT_BITS'(READ_LATENCY - 1);
    localparam logic [ADDR_BITS:0]   DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS-1:0]  LAST      = PTR_BITS'(NUM_CONSUMERS - 1);

    state_t                             state;
    logic [PTR_BITS-1:0]                rr_ptr;
    logic [PTR_BITS-1:0]                gnt_idx;
    logic [NUM_CONSUMERS-1:0]           gnt_oh;
    logic [NUM_CONSUMERS-1:0]           mask_q;
    logic [NUM_CONSUMERS-1:0]           ready_q;
    logic [CNT_BITS-1:0]                cnt;
    logic [IDX_BITS-1:0]                addr_q;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q;

    logic [PTR_BITS-1:0]      arb_idx;
    logic [NUM_CONSUMERS-1:0] arb_grant;
    logic                     arb_valid;

    logic [DATA_BITS-1:0] mem [DEPTH];

`ifdef PROG_MEM_OOR_CHECK_EN
    logic [ADDR_BITS-1:0] req_addr;
    logic                 oor_q;
    logic                 oor_err_q;
    assign req_addr  = bus.consumer_read_address[arb_idx*ADDR_BITS +: ADDR_BITS];
    assign oor_error = oor_err_q;
`else
    logic [IDX_BITS-1:0] req_addr;
    assign req_addr  = bus.consumer_read_address[arb_idx*ADDR_BITS +: IDX_BITS];
    assign oor_error = 1'b0;
`endif

    rr_arbiter #(
        .N        (NUM_CONSUMERS),
        .PTR_BITS (PTR_BITS)
    ) u_arb (
        .request     (bus.consumer_read_valid),
        .mask        (mask_q),
        .pointer     (rr_ptr),
        .grant       (arb_grant),
        .grant_index (arb_idx),
        .grant_valid (arb_valid)
    );

    // Array is never reset; out-of-range loads are dropped.
    always_ff @(posedge clk) begin
        if (bus.load_valid && ({1'b0, bus.load_address} < DEPTH_LIM))
            mem[bus.load_address[IDX_BITS-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            gnt_oh  <= '0;
            mask_q  <= '0;
            ready_q <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef PROG_MEM_OOR_CHECK_EN
            oor_q     <= 1'b0;
            oor_err_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    mask_q <= '0;
                    if (arb_valid) begin
                        gnt_idx <= arb_idx;
                        gnt_oh  <= arb_grant;
                        addr_q  <= req_addr[IDX_BITS-1:0];
                        cnt     <= CNT_INIT;
                        state   <= WAIT;
`ifdef PROG_MEM_OOR_CHECK_EN
                        oor_q   <= ({1'b0, req_addr} >= DEPTH_LIM);
`endif
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ready_q <= gnt_oh;
                        state   <= RESPOND;
`ifdef PROG_MEM_OOR_CHECK_EN
                        data_q[gnt_idx*DATA_BITS +: DATA_BITS] <=
                            oor_q ? '0 : mem[addr_q];
                        oor_err_q <= oor_err_q | oor_q;
`else
                        data_q[gnt_idx*DATA_BITS +: DATA_BITS] <= mem[addr_q];
`endif
                    end
                end
                RESPOND: begin
                    // Skip the served channel for exactly one IDLE look.
                    ready_q <= '0;
                    mask_q  <= gnt_oh;
                    rr_ptr  <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                    = (state != IDLE);
    assign bus.consumer_read_ready = ready_q;
    assign bus.consumer_read_data  = data_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Scenario bench for prog_mem_responder; expected responses are
// queued at request time and popped when a ready pulse appears.
module tb_prog_mem_responder;

    localparam int N     = 4;
    localparam int AB    = 8;
    localparam int DB    = 16;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;
`ifdef PROG_MEM_OOR_CHECK_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    typedef struct {
        int            ch;
        logic [DB-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic oor_error;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    prog_mem_responder_if #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB)
    ) bus ();

    prog_mem_responder #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .DEPTH         (DEPTH),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .oor_error (oor_error)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int ch);
        onehot = '0;
        onehot[ch] = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.load_valid   = 1'b1;
        bus.load_address = a;
        bus.load_data    = d;
        tick();
        bus.load_valid   = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic [AB-1:0] a);
        bus.consumer_read_valid[ch] = 1'b1;
        bus.consumer_read_address[ch*AB +: AB] = a;
    endtask

    task automatic wait_ready(input int limit, output int cycles);
        cycles = -1;
        for (int c = 1; c <= limit; c++) begin
            if (cycles < 0) begin
                tick();
                if (bus.consumer_read_ready != '0) cycles = c;
            end
        end
    endtask

    task automatic test_reset();
        bus.consumer_read_valid   = '0;
        bus.consumer_read_address = '0;
        bus.load_valid   = 1'b0;
        bus.load_address = '0;
        bus.load_data    = '0;
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, oor_error, bus.consumer_read_ready} !== '0 ||
            bus.consumer_read_data !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b oor=%b ready=%b data=%h, want all 0",
                     busy, oor_error, bus.consumer_read_ready, bus.consumer_read_data);
        end
        reset = 1'b0;
        tick();
        do_load(8'h05, 16'hA1B2);
        do_load(8'h10, 16'h0000);
        for (int i = 0; i < N; i++)
            do_load(AB'(8'h20 + i), DB'(16'hC0D0 + i));
    endtask

    task automatic test_single();
        exp_t e;
        int   cyc;
        set_req(0, 8'h05);
        sb.push_back('{0, 16'hA1B2});
        tick();
        tests++;
        if (busy !== 1'b1 || bus.consumer_read_ready !== '0) begin
            fails++;
            $display("FAIL single_grant: busy=%b ready=%b, want busy=1 ready=0",
                     busy, bus.consumer_read_ready);
        end
        bus.consumer_read_valid[0] = 1'b0;
        wait_ready(10, cyc);
        tests++;
        if (cyc !== LAT || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: edges=%0d busy=%b, want %0d busy=1",
                     cyc, busy, LAT);
        end
        e = sb.pop_front();
        tests++;
        if (bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL single_resp: ready=%b data=%h, want ready=%b data=%h",
                     bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     onehot(e.ch), e.data);
        end
        tick();
        tests++;
        if (bus.consumer_read_ready !== '0 || busy !== 1'b0 ||
            bus.consumer_read_data[15:0] !== 16'hA1B2) begin
            fails++;
            $display("FAIL single_after: ready=%b busy=%b data=%h, want 0 0 a1b2",
                     bus.consumer_read_ready, busy, bus.consumer_read_data[15:0]);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        int   cyc;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, AB'(8'h20 + i));
        for (int k = 0; k < 5; k++)
            sb.push_back('{k % N, DB'(16'hC0D0 + k % N)});
        for (int k = 0; k < 5; k++) begin
            wait_ready(12, cyc);
            tests++;
            if (cyc !== ((k == 0) ? LAT + 1 : LAT + 2)) begin
                fails++;
                $display("FAIL contention_gap%0d: cycles=%0d, want %0d",
                         k, cyc, (k == 0) ? LAT + 1 : LAT + 2);
            end
            e = sb.pop_front();
            tests++;
            if (bus.consumer_read_ready !== onehot(e.ch) ||
                bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
                fails++;
                $display("FAIL contention_resp%0d: ready=%b data=%h, want ready=%b data=%h",
                         k, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                         onehot(e.ch), e.data);
            end
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
        tests++;
        if (busy !== 1'b0 || bus.consumer_read_ready !== '0) begin
            fails++;
            $display("FAIL contention_idle: busy=%b ready=%b, want 0 0",
                     busy, bus.consumer_read_ready);
        end
    endtask

    task automatic test_held_valid();
        exp_t e;
        int   cyc;
        logic [2:0] seen;
        set_req(2, 8'h22);
        sb.push_back('{2, 16'hC0D2});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== LAT + 1 || bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL held_first: cycles=%0d ready=%b data=%h, want %0d %b %h",
                     cyc, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     LAT + 1, onehot(e.ch), e.data);
        end
        tick();
        seen[0] = busy;
        tick();
        seen[1] = busy;
        tick();
        seen[2] = busy;
        tests++;
        if (seen !== 3'b100) begin
            fails++;
            $display("FAIL held_mask: busy history=%b, want 100", seen);
        end
        sb.push_back('{2, 16'hC0D2});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== LAT || bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL held_regrant: cycles=%0d ready=%b data=%h, want %0d %b %h",
                     cyc, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     LAT, onehot(e.ch), e.data);
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_wait();
        exp_t e;
        int   cyc;
        logic leak;
        set_req(1, 8'h21);
        tick();
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rstwait_grant: busy=%b, want 1", busy);
        end
        bus.consumer_read_valid = '0;
        tick();
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, oor_error, bus.consumer_read_ready} !== '0 ||
            bus.consumer_read_data !== '0) begin
            fails++;
            $display("FAIL rstwait_clear: busy=%b oor=%b ready=%b data=%h, want all 0",
                     busy, oor_error, bus.consumer_read_ready, bus.consumer_read_data);
        end
        leak = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            leak = leak | (bus.consumer_read_ready != '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            leak = leak | (bus.consumer_read_ready != '0);
        end
        tests++;
        if (leak !== 1'b0) begin
            fails++;
            $display("FAIL rstwait_no_ready: pulse seen=%b, want 0", leak);
        end
        set_req(3, 8'h23);
        sb.push_back('{3, 16'hC0D3});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== LAT + 1 || bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL rstwait_next: cycles=%0d ready=%b data=%h, want %0d %b %h",
                     cyc, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     LAT + 1, onehot(e.ch), e.data);
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_load_collision();
        exp_t e;
        int   cyc;
        set_req(0, 8'h10);
        sb.push_back('{0, 16'h0000});
        tick();
        bus.consumer_read_valid = '0;
        tick();
        bus.load_valid   = 1'b1;
        bus.load_address = 8'h10;
        bus.load_data    = 16'h1234;
        tick();
        bus.load_valid   = 1'b0;
        e = sb.pop_front();
        tests++;
        if (bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL collision_old: ready=%b data=%h, want ready=%b data=%h",
                     bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     onehot(e.ch), e.data);
        end
        tick();
        tick();
        set_req(0, 8'h10);
        sb.push_back('{0, 16'h1234});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== LAT + 1 || bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data) begin
            fails++;
            $display("FAIL collision_new: cycles=%0d ready=%b data=%h, want %0d %b %h",
                     cyc, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     LAT + 1, onehot(e.ch), e.data);
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_out_of_range();
        exp_t e;
        int   cyc;
        do_load(8'h90, 16'hDEAD);
        set_req(1, 8'h90);
        sb.push_back('{1, OOR_EN ? 16'h0000 : 16'h1234});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== LAT + 1 || bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data || oor_error !== OOR_EN) begin
            fails++;
            $display("FAIL oor_read: cycles=%0d ready=%b data=%h oor=%b, want %0d %b %h %b",
                     cyc, bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     oor_error, LAT + 1, onehot(e.ch), e.data, OOR_EN);
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
        set_req(2, 8'h10);
        sb.push_back('{2, 16'h1234});
        wait_ready(10, cyc);
        e = sb.pop_front();
        tests++;
        if (bus.consumer_read_ready !== onehot(e.ch) ||
            bus.consumer_read_data[e.ch*DB +: DB] !== e.data || oor_error !== OOR_EN) begin
            fails++;
            $display("FAIL oor_load_ignored: ready=%b data=%h oor=%b, want %b %h %b",
                     bus.consumer_read_ready, bus.consumer_read_data[e.ch*DB +: DB],
                     oor_error, onehot(e.ch), e.data, OOR_EN);
        end
        bus.consumer_read_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (oor_error !== 1'b0) begin
            fails++;
            $display("FAIL oor_reset: oor=%b, want 0", oor_error);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_held_valid();
        test_reset_wait();
        test_load_collision();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
